out_channel_fifo: RTL and testbench

- Downstream stage of the program-execution core.
- Captures each word the core's `out` instruction writes and holds it in a bounded FIFO.
- Drains the FIFO to a host/checker over a valid/ready handshake.
- Flags overflow and signals when the program has finished and every output word has been consumed.

---
 rtl/out_channel_fifo.sv | 102 ++++++++++
 tb/tb_out_channel_fifo.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/out_channel_fifo.sv
// Output-word FIFO behind the core's `out` instruction: words are visible one cycle after the write, in write order.
// Backpressure: outValue is held while outReady=0; a write to a full FIFO with no pop is dropped and sets sticky overflow.
module out_channel_fifo #(
    parameter int MemoryElementWidth = 12,
    parameter int NOut               = 3
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          outWrite,
    input  logic [MemoryElementWidth-1:0] outData,
    input  logic                          programFinished,
    output logic                          outValid,
    input  logic                          outReady,
    output logic [MemoryElementWidth-1:0] outValue,
    output logic [$clog2(NOut+1)-1:0]     count,
    output logic                          overflow,
    output logic                          drained,
    output logic [15:0]                   wordsOut
);
    localparam int PW = (NOut > 1) ? $clog2(NOut) : 1;
    localparam int CW = $clog2(NOut + 1);

    logic [MemoryElementWidth-1:0] r_mem [NOut];
    logic [PW-1:0]                 r_wp;
    logic [PW-1:0]                 r_rp;
    logic [CW-1:0]                 r_count;
    logic                          r_valid;
    logic [MemoryElementWidth-1:0] r_value;
    logic                          r_overflow;
    logic                          r_finished;
    logic                          r_drained;
    logic [15:0]                   r_words;

    logic                          w_pop;
    logic                          w_push;
    logic [PW-1:0]                 w_rp_nxt;
    logic [CW-1:0]                 w_cnt_nxt;
    logic                          w_rest_empty;
    logic [MemoryElementWidth-1:0] w_head_nxt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NOut - 1)) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        w_pop        = r_valid && outReady;
        w_push       = outWrite && ((r_count < CW'(NOut)) || w_pop);
        w_rp_nxt     = w_pop ? ptr_inc(r_rp) : r_rp;
        w_cnt_nxt    = r_count + CW'(w_push) - CW'(w_pop);
        // Nothing older survives this cycle, so the new head is the word being written now.
        w_rest_empty = (r_count == CW'(w_pop));
        w_head_nxt   = w_rest_empty ? outData : r_mem[w_rp_nxt];
    end

    always_ff @(posedge clock) begin
        if (!reset && w_push) begin
            r_mem[r_wp] <= outData;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wp       <= '0;
            r_rp       <= '0;
            r_count    <= '0;
            r_valid    <= 1'b0;
            r_value    <= '0;
            r_overflow <= 1'b0;
            r_finished <= 1'b0;
            r_drained  <= 1'b0;
            r_words    <= '0;
        end else begin
            if (w_push) begin
                r_wp <= ptr_inc(r_wp);
            end
            r_rp    <= w_rp_nxt;
            r_count <= w_cnt_nxt;
            r_valid <= (w_cnt_nxt != '0);
            // Empty FIFO keeps the last presented word on outValue.
            if (w_cnt_nxt != '0) begin
                r_value <= w_head_nxt;
            end
            if (outWrite && !w_push) begin
                r_overflow <= 1'b1;
            end
            if (programFinished) begin
                r_finished <= 1'b1;
            end
            r_drained <= r_finished && (r_count == '0);
            if (w_pop && (r_words != 16'hFFFF)) begin
                r_words <= r_words + 16'd1;
            end
        end
    end

    assign outValid = r_valid;
    assign outValue = r_value;
    assign count    = r_count;
    assign overflow = r_overflow;
    assign drained  = r_drained;
    assign wordsOut = r_words;
endmodule

// File: tb/tb_out_channel_fifo.sv
// Bench for out_channel_fifo: directed scenarios plus random traffic checked against a queue-based model.
module tb_out_channel_fifo;
    localparam int W = 12;
    localparam int N = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         outWrite = 1'b0;
    logic [W-1:0] outData = '0;
    logic         programFinished = 1'b0;
    logic         outValid;
    logic         outReady = 1'b0;
    logic [W-1:0] outValue;
    logic [$clog2(N+1)-1:0] count;
    logic         overflow;
    logic         drained;
    logic [15:0]  wordsOut;

    out_channel_fifo #(.MemoryElementWidth(W), .NOut(N)) dut (
        .clock(clock), .reset(reset), .outWrite(outWrite), .outData(outData),
        .programFinished(programFinished), .outValid(outValid), .outReady(outReady),
        .outValue(outValue), .count(count), .overflow(overflow), .drained(drained),
        .wordsOut(wordsOut)
    );

    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: a plain queue of held words plus the sticky flags.
    int       mq[$];
    int       dut_pop[$];
    int       exp_q[$];
    bit       m_ovf, m_fin, m_dr;
    int       m_words;
    int       m_held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_update(input bit wr, input int d, input bit rdy, input bit fin, input bit rst);
        int  sz;
        bit  pop, push;
        sz   = mq.size();
        pop  = (sz > 0) && rdy;
        push = wr && ((sz < N) || pop);
        if (rst) begin
            mq.delete();
            m_ovf = 0; m_fin = 0; m_dr = 0; m_words = 0; m_held = 0;
        end else begin
            m_dr = m_fin && (sz == 0);
            if (pop) begin
                void'(mq.pop_front());
                if (m_words < 65535) m_words++;
            end
            if (push) mq.push_back(d);
            else if (wr) m_ovf = 1;
            if (fin) m_fin = 1;
            if (mq.size() > 0) m_held = mq[0];
        end
    endtask

    task automatic check_all();
        chk("outValid", 32'(outValid), 32'(mq.size() != 0));
        chk("outValue", 32'(outValue), m_held);
        chk("count",    32'(count),    mq.size());
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("drained",  32'(drained),  32'(m_dr));
        chk("wordsOut", 32'(wordsOut), m_words);
    endtask

    task automatic step(input bit wr, input int d, input bit rdy, input bit fin, input bit rst);
        outWrite = wr; outData = W'(d); outReady = rdy; programFinished = fin; reset = rst;
        if (!rst && rdy && outValid === 1'b1) dut_pop.push_back(int'(outValue));
        @(posedge clock);
        model_update(wr, d, rdy, fin, rst);
        #1;
        check_all();
    endtask

    task automatic chk_seq(input string tag);
        chk({tag, "_len"}, dut_pop.size(), exp_q.size());
        for (int i = 0; i < dut_pop.size() && i < exp_q.size(); i++)
            chk(tag, dut_pop[i], exp_q[i]);
        dut_pop.delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        bit rdy;

        // Reset state
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 1);
        dut_pop.delete();

        // Basic order with the consumer always ready
        step(1, 11, 1, 0, 0);
        chk("basic_first_valid", 32'(outValid), 1);
        step(1, 22, 1, 0, 0);
        step(1, 33, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        exp_q = '{11, 22, 33};
        chk_seq("basic_seq");
        chk("basic_words", 32'(wordsOut), 3);
        chk("basic_count", 32'(count), 0);

        // Backpressure and overflow
        step(0, 0, 0, 0, 1);
        dut_pop.delete();
        step(1, 11, 0, 0, 0);
        step(1, 22, 0, 0, 0);
        step(1, 33, 0, 0, 0);
        step(1, 44, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("bp_count", 32'(count), 3);
        chk("bp_head", 32'(outValue), 11);
        chk("bp_overflow", 32'(overflow), 1);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        exp_q = '{11, 22, 33};
        chk_seq("bp_seq");

        // Full with simultaneous write and pop
        step(0, 0, 0, 0, 1);
        dut_pop.delete();
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        step(1, 4, 1, 0, 0);
        chk("fullpop_count", 32'(count), 3);
        chk("fullpop_ovf", 32'(overflow), 0);
        for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 0);
        exp_q = '{1, 2, 3, 4};
        chk_seq("fullpop_seq");

        // Pointer wrap with random readiness, each word held until accepted
        step(0, 0, 0, 0, 1);
        dut_pop.delete();
        idx = 0;
        for (int c = 0; c < 200 && idx < 10; c++) begin
            rdy = 1'($urandom % 2);
            if (mq.size() < N || (rdy && mq.size() > 0)) begin
                step(1, 100 + idx, rdy, 0, 0);
                idx++;
            end else begin
                step(1, 100 + idx, rdy, 0, 0);
            end
        end
        for (int c = 0; c < 10 && mq.size() > 0; c++) step(0, 0, 1, 0, 0);
        exp_q.delete();
        for (int i = 0; i < 10; i++) exp_q.push_back(100 + i);
        chk_seq("wrap_seq");
        chk("wrap_words", 32'(wordsOut), 10);

        // Drained tracking, including a late write
        step(0, 0, 0, 0, 1);
        dut_pop.delete();
        step(1, 11, 0, 0, 0);
        step(1, 22, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        chk("drained_busy", 32'(drained), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        chk("drained_set", 32'(drained), 1);
        step(1, 5, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("drained_late_write", 32'(drained), 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 0);
        chk("drained_again", 32'(drained), 1);
        dut_pop.delete();

        // Reset in the middle of traffic
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        step(1, 4, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("mid_count_pre", 32'(count), 2);
        chk("mid_ovf_pre", 32'(overflow), 1);
        step(0, 0, 1, 0, 1);
        chk("mid_reset_value", 32'(outValue), 0);
        step(1, 7, 0, 0, 0);
        chk("mid_value", 32'(outValue), 7);
        chk("mid_count", 32'(count), 1);
        step(0, 0, 1, 0, 0);
        dut_pop.delete();

        // Random traffic
        for (int c = 0; c < 400; c++) begin
            step(1'($urandom % 2), int'($urandom % 4096), 1'($urandom % 2),
                 ($urandom % 32) == 0, ($urandom % 64) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
